pkt_arb_2to1: RTL and testbench

Packet-granular 2:1 AXI-Stream arbiter that merges two 256-bit packet streams into the single ingress of the RMT pipeline, for example two filtered port streams ahead of the parser. It grants one input per packet and holds the grant until that packet's tlast beat transfers. Arbitration is round-robin by default; a strict-priority mode favours input 0. The output is registered and honours back-pressure. Per-input packet counters expose the traffic mix to the control path.

---
 rtl/pkt_arb_2to1.sv | 192 +++++++++++++++++++
 tb/tb_pkt_arb_2to1.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_arb_2to1.sv
// -----------------------------------------------------------------------------
// pkt_arb_2to1
// Packet-granular 2:1 AXI-Stream arbiter. One input is granted per packet and
// the grant is held until that packet's tlast beat transfers. Ties are broken
// round-robin, or in favour of input 0 when prio_mode is set. The merged output
// is a single register stage that honours downstream back-pressure.
//
// Ports
//   clk, aresetn          clock, asynchronous active-low reset
//   prio_mode             0 = round-robin, 1 = strict priority to input 0
//   s0_axis_*             input stream 0 (tdata/tkeep/tuser/tvalid/tlast, tready out)
//   s1_axis_*             input stream 1 (tdata/tkeep/tuser/tvalid/tlast, tready out)
//   m_axis_*              merged output stream (registered), m_axis_tready in
//   pkt_cnt0, pkt_cnt1    wrapping 32-bit counts of packets accepted per input
// -----------------------------------------------------------------------------
module pkt_arb_2to1 #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic                                 prio_mode,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s0_axis_tuser,
  input  logic                                 s0_axis_tvalid,
  input  logic                                 s0_axis_tlast,
  output logic                                 s0_axis_tready,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s1_axis_tuser,
  input  logic                                 s1_axis_tvalid,
  input  logic                                 s1_axis_tlast,
  output logic                                 s1_axis_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,

  output logic [31:0]                          pkt_cnt0,
  output logic [31:0]                          pkt_cnt1
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e                            state_q, state_d;
  logic                              last_grant_q, last_grant_d;
  logic [31:0]                       cnt0_q, cnt0_d;
  logic [31:0]                       cnt1_q, cnt1_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
  logic [KEEP_W-1:0]                 m_tkeep_q, m_tkeep_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
  logic                              m_tvalid_q, m_tvalid_d;
  logic                              m_tlast_q, m_tlast_d;

  logic                              out_free_s;
  logic                              s0_ready_s;
  logic                              s1_ready_s;
  logic                              hs0_s;
  logic                              hs1_s;

  // The output slot can take a beat when empty or when it drains this cycle,
  // so readiness follows m_axis_tready combinationally (no bubble under stall
  // release). Only the granted input ever sees ready; IDLE keeps both low.
  assign out_free_s = ~m_tvalid_q | m_axis_tready;
  assign s0_ready_s = (state_q == GRANT0) & out_free_s;
  assign s1_ready_s = (state_q == GRANT1) & out_free_s;
  assign hs0_s      = s0_axis_tvalid & s0_ready_s;
  assign hs1_s      = s1_axis_tvalid & s1_ready_s;

  assign s0_axis_tready = s0_ready_s;
  assign s1_axis_tready = s1_ready_s;
  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tkeep   = m_tkeep_q;
  assign m_axis_tuser   = m_tuser_q;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tlast   = m_tlast_q;
  assign pkt_cnt0       = cnt0_q;
  assign pkt_cnt1       = cnt1_q;

  // Next-state logic: output register load/drain, grant FSM and counters.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    m_tuser_d    = m_tuser_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;

    // At most one handshake can be active because only one input is granted.
    if (hs0_s) begin
      m_tdata_d  = s0_axis_tdata;
      m_tkeep_d  = s0_axis_tkeep;
      m_tuser_d  = s0_axis_tuser;
      m_tlast_d  = s0_axis_tlast;
      m_tvalid_d = 1'b1;
    end else if (hs1_s) begin
      m_tdata_d  = s1_axis_tdata;
      m_tkeep_d  = s1_axis_tkeep;
      m_tuser_d  = s1_axis_tuser;
      m_tlast_d  = s1_axis_tlast;
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end

    case (state_q)
      IDLE: begin
        // prio_mode is only looked at here, so mid-packet changes wait for
        // the next arbitration decision.
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          if (prio_mode) begin
            state_d = GRANT0;
          end else if (last_grant_q) begin
            state_d = GRANT0;
          end else begin
            state_d = GRANT1;
          end
        end else if (s0_axis_tvalid) begin
          state_d = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (hs0_s && s0_axis_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          cnt0_d       = cnt0_q + 32'd1;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        if (hs1_s && s1_axis_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          cnt1_d       = cnt1_q + 32'd1;
        end else begin
          state_d = GRANT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset truncates any packet in flight (no tlast emitted).
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt0_q       <= 32'd0;
      cnt1_q       <= 32'd0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      m_tuser_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      m_tdata_q    <= m_tdata_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tuser_q    <= m_tuser_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
    end
  end

endmodule

// File: tb/tb_pkt_arb_2to1.sv
// -----------------------------------------------------------------------------
// tb_pkt_arb_2to1
// Self-checking bench for pkt_arb_2to1. Tests push the beats they expect on
// m_axis (in the order the arbitration rules dictate) into a scoreboard queue;
// a monitor pops and compares every beat that transfers on m_axis.
// -----------------------------------------------------------------------------
module tb_pkt_arb_2to1;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } exp_t;

  logic         clk;
  logic         aresetn;
  logic         prio_mode;
  logic [255:0] s_tdata  [2];
  logic [31:0]  s_tkeep  [2];
  logic [127:0] s_tuser  [2];
  logic         s_tvalid [2];
  logic         s_tlast  [2];
  logic         s_tready [2];
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic [31:0]  pkt_cnt0;
  logic [31:0]  pkt_cnt1;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  exp_t exp_q [$];
  int   out_cyc [$];
  logic s1_rdy_seen  = 1'b0;

  pkt_arb_2to1 dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .prio_mode      (prio_mode),
    .s0_axis_tdata  (s_tdata[0]),
    .s0_axis_tkeep  (s_tkeep[0]),
    .s0_axis_tuser  (s_tuser[0]),
    .s0_axis_tvalid (s_tvalid[0]),
    .s0_axis_tlast  (s_tlast[0]),
    .s0_axis_tready (s_tready[0]),
    .s1_axis_tdata  (s_tdata[1]),
    .s1_axis_tkeep  (s_tkeep[1]),
    .s1_axis_tuser  (s_tuser[1]),
    .s1_axis_tvalid (s_tvalid[1]),
    .s1_axis_tlast  (s_tlast[1]),
    .s1_axis_tready (s_tready[1]),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Beat encoding: every field carries source, packet id and beat index.
  function automatic logic [255:0] mk_data(input int src, input int id, input int beat);
    logic [255:0] d;
    logic [31:0]  w;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      w = {src[7:0], id[7:0], beat[7:0], 8'(i)};
      d[i*32 +: 32] = w ^ 32'h5A3C_0000;
    end
    return d;
  endfunction

  function automatic exp_t mk_beat(input int src, input int id, input int beat, input logic last);
    exp_t e;
    e.data = mk_data(src, id, beat);
    e.keep = e.data[31:0] ^ 32'hF0F0_F0F0;
    e.user = ~e.data[255:128];
    e.last = last;
    return e;
  endfunction

  task automatic push_pkt(input int src, input int id, input int nbeats);
    for (int b = 0; b < nbeats; b++) exp_q.push_back(mk_beat(src, id, b, (b == nbeats - 1)));
  endtask

  task automatic drive_beat(input int src, input int id, input int beat, input logic last);
    exp_t e;
    e = mk_beat(src, id, beat, last);
    s_tdata[src]  = e.data;
    s_tkeep[src]  = e.keep;
    s_tuser[src]  = e.user;
    s_tlast[src]  = e.last;
    s_tvalid[src] = 1'b1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input int src, input int first_id, input int npkts, input int nbeats);
    logic hs;
    int   waited;
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < nbeats; b++) begin
        drive_beat(src, first_id + p, b, (b == nbeats - 1));
        waited = 0;
        do begin
          @(negedge clk);
          hs = s_tready[src];
          @(posedge clk);
          #1;
          waited++;
        end while (!hs && waited < 200);
        if (!hs) begin
          tests_run++;
          tests_failed++;
          $display("FAIL send_timeout: src=%0d pkt=%0d beat=%0d got no tready, required tready within 200 cycles", src, first_id + p, b);
          s_tvalid[src] = 1'b0;
          return;
        end
      end
    end
    s_tvalid[src] = 1'b0;
    s_tlast[src]  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d expected beats never appeared, required 0 outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    s_tvalid[0] = 1'b0;
    s_tvalid[1] = 1'b0;
    s_tlast[0]  = 1'b0;
    s_tlast[1]  = 1'b0;
    m_tready    = 1'b1;
    prio_mode   = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    out_cyc.delete();
  endtask

  // Monitor: scoreboard compare on every transfer, plus stall stability.
  initial begin
    exp_t         e;
    logic         prev_stall;
    logic [255:0] prev_data;
    logic         prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (s_tready[1]) s1_rdy_seen = 1'b1;
        if (prev_stall) begin
          tests_run++;
          if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
            tests_failed++;
            $display("FAIL stall_hold: got valid=%b data[31:0]=%h last=%b, required valid=1 data[31:0]=%h last=%b",
                     m_tvalid, m_tdata[31:0], m_tlast, prev_data[31:0], prev_last);
          end
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
          out_cyc.push_back(cyc);
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL beat_unexpected: got data[31:0]=%h last=%b, required no beat", m_tdata[31:0], m_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tkeep !== e.keep || m_tuser !== e.user || m_tlast !== e.last) begin
              tests_failed++;
              $display("FAIL beat: got data[31:0]=%h keep=%h last=%b, required data[31:0]=%h keep=%h last=%b",
                       m_tdata[31:0], m_tkeep, m_tlast, e.data[31:0], e.keep, e.last);
            end
          end
        end
        prev_stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  task automatic test_reset();
    aresetn = 1'b1;
    #3;
    aresetn = 1'b0;
    #2;
    tests_run++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 256'd0 || m_tkeep !== 32'd0 || m_tuser !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_m_axis: got valid=%b last=%b data[31:0]=%h keep=%h, required all 0", m_tvalid, m_tlast, m_tdata[31:0], m_tkeep);
    end
    tests_run++;
    if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tready: got %b%b, required 00", s_tready[0], s_tready[1]);
    end
    tests_run++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %h/%h, required 0/0", pkt_cnt0, pkt_cnt1);
    end
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_single_source();
    int start;
    apply_reset();
    s1_rdy_seen = 1'b0;
    push_pkt(0, 1, 3);
    start = cyc;
    send(0, 1, 1, 3);
    drain("single");
    tests_run++;
    if (out_cyc.size() != 3 || out_cyc[0] - start != 2 || out_cyc[2] - out_cyc[0] != 2) begin
      tests_failed++;
      $display("FAIL single_timing: got %0d beats first at +%0d, required 3 consecutive beats at +2", out_cyc.size(),
               (out_cyc.size() > 0) ? out_cyc[0] - start : -1);
    end
    tests_run++;
    if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL single_cnt: got %0d/%0d, required 1/0", pkt_cnt0, pkt_cnt1);
    end
    tests_run++;
    if (s1_rdy_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_s1_ready: got s1 tready high, required always 0");
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    push_pkt(0, 10, 2);
    push_pkt(1, 20, 2);
    push_pkt(0, 11, 2);
    push_pkt(1, 21, 2);
    fork
      send(0, 10, 2, 2);
      send(1, 20, 2, 2);
    join
    drain("rr");
    tests_run++;
    if (pkt_cnt0 !== 32'd2 || pkt_cnt1 !== 32'd2) begin
      tests_failed++;
      $display("FAIL rr_cnt: got %0d/%0d, required 2/2", pkt_cnt0, pkt_cnt1);
    end
    tests_run++;
    if (out_cyc.size() != 8 || out_cyc[1] - out_cyc[0] != 1 || out_cyc[2] - out_cyc[1] != 2) begin
      tests_failed++;
      $display("FAIL rr_gap: got %0d beats, required 8 with a 1-cycle gap between packets", out_cyc.size());
    end
  endtask

  task automatic test_strict_priority();
    apply_reset();
    prio_mode = 1'b1;
    push_pkt(0, 30, 2);
    push_pkt(0, 31, 2);
    push_pkt(0, 32, 2);
    push_pkt(1, 40, 1);
    fork
      send(0, 30, 3, 2);
      send(1, 40, 1, 1);
    join
    drain("prio");
    tests_run++;
    if (pkt_cnt0 !== 32'd3 || pkt_cnt1 !== 32'd1) begin
      tests_failed++;
      $display("FAIL prio_cnt: got %0d/%0d, required 3/1", pkt_cnt0, pkt_cnt1);
    end
    tests_run++;
    if (out_cyc.size() != 7 || out_cyc[6] - out_cyc[5] != 2) begin
      tests_failed++;
      $display("FAIL prio_gap: got %0d beats, required 7 with s1 one IDLE cycle after s0", out_cyc.size());
    end
  endtask

  task automatic test_back_pressure();
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int n;
    apply_reset();
    m_tready = 1'b0;
    push_pkt(1, 50, 4);
    fork
      send(1, 50, 1, 4);
      begin
        n = 0;
        while (m_tvalid !== 1'b1 && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        for (int i = 0; i < 7; i++) begin
          m_tready = pat[i][0];
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    drain("bp");
    tests_run++;
    if (pkt_cnt1 !== 32'd1 || out_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count: got cnt1=%0d beats=%0d, required 1 and 4", pkt_cnt1, out_cyc.size());
    end
  endtask

  task automatic test_wrap_atomicity();
    apply_reset();
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0_q;
    tests_run++;
    if (pkt_cnt0 !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL wrap_preset: got %h, required ffffffff", pkt_cnt0);
    end
    @(posedge clk);
    #1;
    push_pkt(0, 70, 2);
    send(0, 70, 1, 2);
    drain("wrap");
    tests_run++;
    if (pkt_cnt0 !== 32'd0) begin
      tests_failed++;
      $display("FAIL wrap_cnt: got %h, required 00000000", pkt_cnt0);
    end
    push_pkt(0, 71, 5);
    push_pkt(1, 80, 2);
    fork
      send(0, 71, 1, 5);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1, 80, 1, 2);
      end
    join
    drain("atomic");
    tests_run++;
    if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd1) begin
      tests_failed++;
      $display("FAIL atomic_cnt: got %0d/%0d, required 1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    push_pkt(0, 90, 1);
    send(0, 90, 1, 1);
    drain("rst_pre");
    exp_q.push_back(mk_beat(0, 91, 0, 1'b0));
    drive_beat(0, 91, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive_beat(0, 91, 1, 1'b0);
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    #1;
    tests_run++;
    if (m_tvalid !== 1'b0 || s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got valid=%b tready=%b%b, required 0 and 00", m_tvalid, s_tready[0], s_tready[1]);
    end
    tests_run++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
    s_tvalid[0] = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    drain("rst_mid");
    push_pkt(1, 92, 2);
    send(1, 92, 1, 2);
    drain("rst_post");
    tests_run++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd1) begin
      tests_failed++;
      $display("FAIL rst_post_cnt: got %0d/%0d, required 0/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  initial begin
    aresetn     = 1'b1;
    prio_mode   = 1'b0;
    m_tready    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i]  = '0;
      s_tkeep[i]  = '0;
      s_tuser[i]  = '0;
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
    end
    test_reset();
    test_single_source();
    test_round_robin();
    test_strict_priority();
    test_back_pressure();
    test_wrap_atomicity();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
